// File: rtl/mips_cpu_avalon_master.sv
// Avalon-MM bus master for the MIPS core: arbitrates fetch and load/store ports,
// steers byte lanes, replicates store data and sign/zero-extends load results.
module mips_cpu_avalon_master #(
  parameter int DATA_PRIORITY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_instr,
  output logic        if_error,
  input  logic        dm_req,
  input  logic        dm_write,
  input  logic [1:0]  dm_size,
  input  logic        dm_signed,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ready,
  output logic [31:0] dm_rdata,
  output logic        dm_error,
  output logic [31:0] address,
  output logic [3:0]  byteenable,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_RDATA, S_ERR, S_RESP} state_t;

  state_t      state_q;
  logic        port_q, op_write_q, op_signed_q;
  logic [1:0]  op_size_q, op_ofs_q;
  logic        read_q, write_q, busy_q;
  logic [31:0] address_q, writedata_q;
  logic [3:0]  byteenable_q;
  logic        if_ready_q, if_error_q, dm_ready_q, dm_error_q;
  logic [31:0] if_instr_q, dm_rdata_q;

  logic        sel_data_s, any_req_s, req_write_s, req_bad_s;
  logic [31:0] req_addr_s;
  logic [1:0]  req_size_s;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] ofs);
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = ofs[0];
      2'b10:   misaligned = (ofs != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] ofs);
    case (size)
      2'b00:   lane_enables = 4'b0001 << ofs;
      2'b01:   lane_enables = ofs[1] ? 4'b1100 : 4'b0011;
      default: lane_enables = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   replicate = {4{wd[7:0]}};
      2'b01:   replicate = {2{wd[15:0]}};
      default: replicate = wd;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [1:0] size, input logic [1:0] ofs,
                                          input logic sgn, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (ofs)
      2'b00:   b = rd[7:0];
      2'b01:   b = rd[15:8];
      2'b10:   b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = ofs[1] ? rd[31:16] : rd[15:0];
    case (size)
      2'b00:   extract = {{24{sgn & b[7]}}, b};
      2'b01:   extract = {{16{sgn & h[15]}}, h};
      default: extract = rd;
    endcase
  endfunction

  // Arbitration and operand selection for the request sampled in IDLE.
  always_comb begin
    any_req_s  = if_req | dm_req;
    sel_data_s = dm_req & (~if_req | (DATA_PRIORITY != 0));
    if (sel_data_s) begin
      req_addr_s  = dm_addr;
      req_size_s  = dm_size;
      req_write_s = dm_write;
    end else begin
      req_addr_s  = if_addr;
      req_size_s  = 2'b10;
      req_write_s = 1'b0;
    end
    req_bad_s = misaligned(req_size_s, req_addr_s[1:0]);
  end

  // Transaction FSM with registered bus and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      port_q       <= 1'b0;
      op_write_q   <= 1'b0;
      op_signed_q  <= 1'b0;
      op_size_q    <= 2'b00;
      op_ofs_q     <= 2'b00;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      busy_q       <= 1'b0;
      address_q    <= 32'd0;
      writedata_q  <= 32'd0;
      byteenable_q <= 4'd0;
      if_ready_q   <= 1'b0;
      if_error_q   <= 1'b0;
      dm_ready_q   <= 1'b0;
      dm_error_q   <= 1'b0;
      if_instr_q   <= 32'd0;
      dm_rdata_q   <= 32'd0;
    end else begin
      if_ready_q <= 1'b0;
      if_error_q <= 1'b0;
      dm_ready_q <= 1'b0;
      dm_error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_req_s) begin
            port_q      <= sel_data_s;
            op_write_q  <= req_write_s;
            op_signed_q <= dm_signed;
            op_size_q   <= req_size_s;
            op_ofs_q    <= req_addr_s[1:0];
            busy_q      <= 1'b1;
            if (req_bad_s) begin
              state_q <= S_ERR;
            end else begin
              state_q      <= S_ISSUE;
              address_q    <= {req_addr_s[31:2], 2'b00};
              byteenable_q <= lane_enables(req_size_s, req_addr_s[1:0]);
              writedata_q  <= req_write_s ? replicate(req_size_s, dm_wdata) : 32'd0;
              read_q       <= ~req_write_s;
              write_q      <= req_write_s;
            end
          end
        end
        S_ISSUE: begin
          if (!waitrequest) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            if (op_write_q) begin
              state_q    <= S_RESP;
              dm_ready_q <= 1'b1;
              dm_rdata_q <= 32'd0;
            end else begin
              state_q <= S_RDATA;
            end
          end
        end
        S_RDATA: begin
          state_q <= S_RESP;
          if (port_q) begin
            dm_ready_q <= 1'b1;
            dm_rdata_q <= extract(op_size_q, op_ofs_q, op_signed_q, readdata);
          end else begin
            if_ready_q <= 1'b1;
            if_instr_q <= readdata;
          end
        end
        S_ERR: begin
          state_q <= S_RESP;
          if (port_q) begin
            dm_ready_q <= 1'b1;
            dm_error_q <= 1'b1;
            dm_rdata_q <= 32'd0;
          end else begin
            if_ready_q <= 1'b1;
            if_error_q <= 1'b1;
            if_instr_q <= 32'd0;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          read_q  <= 1'b0;
          write_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign address    = address_q;
  assign byteenable = byteenable_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = writedata_q;
  assign busy       = busy_q;
  assign if_ready   = if_ready_q;
  assign if_instr   = if_instr_q;
  assign if_error   = if_error_q;
  assign dm_ready   = dm_ready_q;
  assign dm_rdata   = dm_rdata_q;
  assign dm_error   = dm_error_q;

endmodule

// File: tb/tb_mips_cpu_avalon_master.sv
// Directed bench for mips_cpu_avalon_master: scoreboard of expected responses,
// cycle-stepped Avalon slave driven from the stimulus thread.
module tb_mips_cpu_avalon_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_ready, if_error;
  logic [31:0] if_addr, if_instr;
  logic        dm_req, dm_write, dm_signed, dm_ready, dm_error;
  logic [1:0]  dm_size;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [31:0] address, writedata, readdata;
  logic [3:0]  byteenable;
  logic        read, write, waitrequest, busy;

  always #5 clk = ~clk;

  mips_cpu_avalon_master #(.DATA_PRIORITY(1)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_instr(if_instr), .if_error(if_error),
    .dm_req(dm_req), .dm_write(dm_write), .dm_size(dm_size), .dm_signed(dm_signed),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata), .dm_error(dm_error),
    .address(address), .byteenable(byteenable), .read(read), .write(write), .writedata(writedata),
    .waitrequest(waitrequest), .readdata(readdata), .busy(busy)
  );

  typedef struct {
    bit          port;
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] mem;
    int          waits;
    logic [31:0] rdata;
    bit          err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit port, input bit wr, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wdata, input logic [31:0] mem, input int waits,
                      input logic [31:0] rdata, input bit err, input int lat);
    exp_t e;
    e.port = port; e.wr = wr; e.addr = addr; e.be = be; e.wdata = wdata; e.mem = mem;
    e.waits = waits; e.rdata = rdata; e.err = err; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic data_req(input bit wr, input logic [1:0] size, input bit sgn,
                          input logic [31:0] addr, input logic [31:0] wd);
    dm_req = 1'b1; dm_write = wr; dm_size = size; dm_signed = sgn; dm_addr = addr; dm_wdata = wd;
  endtask

  task automatic fetch_req(input logic [31:0] addr);
    if_req = 1'b1; if_addr = addr;
  endtask

  // Steps the clock until every queued response is seen, acting as the Avalon slave.
  task automatic run(input int exp_idle);
    int   k = 0;
    int   bus_cnt = 0;
    int   idle_cnt = 0;
    bit   rd_pend = 1'b0;
    exp_t e;
    while (sb.size() > 0 && k < 60) begin
      @(negedge clk);
      k++;
      readdata = rd_pend ? sb[0].mem : 32'hDEADBEEF;
      rd_pend = 1'b0;
      if (!busy) idle_cnt++;
      if (if_ready || dm_ready) begin
        e = sb.pop_front();
        chk("ready_port", {30'd0, if_ready, dm_ready}, e.port ? 32'd1 : 32'd2);
        chk("rdata", e.port ? dm_rdata : if_instr, e.rdata);
        chk("error", {31'd0, e.port ? dm_error : if_error}, {31'd0, e.err});
        chk("latency", k, e.lat);
        chk("bus_cycles", bus_cnt, e.err ? 0 : e.waits + 1);
        bus_cnt = 0;
        if (e.port) dm_req = 1'b0;
        else if_req = 1'b0;
      end
      if (read || write) begin
        if (sb.size() == 0) begin
          chk("spurious_bus", 32'd1, 32'd0);
          waitrequest = 1'b0;
        end else begin
          chk("rw", {30'd0, read, write}, sb[0].wr ? 32'd1 : 32'd2);
          chk("address", address, sb[0].addr);
          chk("byteenable", {28'd0, byteenable}, {28'd0, sb[0].be});
          if (sb[0].wr) chk("writedata", writedata, sb[0].wdata);
          waitrequest = (bus_cnt < sb[0].waits);
          if (!waitrequest && read) rd_pend = 1'b1;
          bus_cnt++;
        end
      end else begin
        waitrequest = 1'b1;
      end
    end
    if (sb.size() != 0) begin
      chk("timeout_pending", sb.size(), 0);
      sb.delete();
    end
    chk("idle_cycles", idle_cnt, exp_idle);
    if_req = 1'b0;
    dm_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    if_req = 1'b0; if_addr = 32'd0;
    dm_req = 1'b0; dm_write = 1'b0; dm_size = 2'b00; dm_signed = 1'b0;
    dm_addr = 32'd0; dm_wdata = 32'd0;
    waitrequest = 1'b1; readdata = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    chk("rst_rw", {30'd0, read, write}, 32'd0);
    chk("rst_address", address, 32'd0);
    chk("rst_be_wd", {28'd0, byteenable} | writedata, 32'd0);
    chk("rst_pulses", {28'd0, if_ready, if_error, dm_ready, dm_error}, 32'd0);
    chk("rst_data", if_instr | dm_rdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Fetch, zero wait
    push(1'b0, 1'b0, 32'hBFC00000, 4'b1111, 32'd0, 32'h24020005, 0, 32'h24020005, 1'b0, 3);
    fetch_req(32'hBFC00000);
    run(0);

    // Store byte with three wait cycles
    push(1'b1, 1'b1, 32'hBFC00100, 4'b0100, 32'hABABABAB, 32'd0, 3, 32'd0, 1'b0, 5);
    data_req(1'b1, 2'b00, 1'b0, 32'hBFC00102, 32'h000000AB);
    run(0);

    // Load half signed / unsigned, byte loads
    push(1'b1, 1'b0, 32'hBFC00100, 4'b1100, 32'd0, 32'h80F01234, 0, 32'hFFFF80F0, 1'b0, 3);
    data_req(1'b0, 2'b01, 1'b1, 32'hBFC00102, 32'd0);
    run(0);
    push(1'b1, 1'b0, 32'hBFC00100, 4'b1100, 32'd0, 32'h80F01234, 1, 32'h000080F0, 1'b0, 4);
    data_req(1'b0, 2'b01, 1'b0, 32'hBFC00102, 32'd0);
    run(0);
    push(1'b1, 1'b0, 32'hBFC00100, 4'b0001, 32'd0, 32'h80F01234, 0, 32'h00000034, 1'b0, 3);
    data_req(1'b0, 2'b00, 1'b1, 32'hBFC00100, 32'd0);
    run(0);
    push(1'b1, 1'b0, 32'hBFC00100, 4'b1000, 32'd0, 32'h80F01234, 0, 32'hFFFFFF80, 1'b0, 3);
    data_req(1'b0, 2'b00, 1'b1, 32'hBFC00103, 32'd0);
    run(0);

    // Word load ignores dm_signed; halfword store replication
    push(1'b1, 1'b0, 32'hBFC00008, 4'b1111, 32'd0, 32'h80000001, 0, 32'h80000001, 1'b0, 3);
    data_req(1'b0, 2'b10, 1'b1, 32'hBFC00008, 32'd0);
    run(0);
    push(1'b1, 1'b1, 32'hBFC00010, 4'b1100, 32'hABCDABCD, 32'd0, 0, 32'd0, 1'b0, 2);
    data_req(1'b1, 2'b01, 1'b0, 32'hBFC00012, 32'h1234ABCD);
    run(0);

    // Simultaneous requests: data first, fetch from the next IDLE
    push(1'b1, 1'b1, 32'hBFC00010, 4'b1111, 32'h12345678, 32'd0, 0, 32'd0, 1'b0, 2);
    push(1'b0, 1'b0, 32'hBFC00004, 4'b1111, 32'd0, 32'h3C08BFC0, 0, 32'h3C08BFC0, 1'b0, 6);
    data_req(1'b1, 2'b10, 1'b0, 32'hBFC00010, 32'h12345678);
    fetch_req(32'hBFC00004);
    run(1);

    // Alignment and illegal-size errors
    push(1'b1, 1'b0, 32'd0, 4'd0, 32'd0, 32'd0, 0, 32'd0, 1'b1, 2);
    data_req(1'b0, 2'b10, 1'b0, 32'hBFC00006, 32'd0);
    run(0);
    push(1'b1, 1'b0, 32'd0, 4'd0, 32'd0, 32'd0, 0, 32'd0, 1'b1, 2);
    data_req(1'b0, 2'b11, 1'b0, 32'hBFC00008, 32'd0);
    run(0);
    push(1'b1, 1'b1, 32'd0, 4'd0, 32'd0, 32'd0, 0, 32'd0, 1'b1, 2);
    data_req(1'b1, 2'b01, 1'b0, 32'hBFC00011, 32'h00005555);
    run(0);
    push(1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 32'd0, 0, 32'd0, 1'b1, 2);
    fetch_req(32'hBFC00002);
    run(0);

    // Reset while a fetch is stalled in ISSUE
    fetch_req(32'hBFC00020);
    waitrequest = 1'b1;
    @(negedge clk);
    chk("stall_read", {31'd0, read}, 32'd1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_drop_rw", {30'd0, read, write}, 32'd0);
    chk("rst_drop_busy", {31'd0, busy}, 32'd0);
    if_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_ready_after_reset", {30'd0, if_ready, dm_ready}, 32'd0);
    end
    push(1'b0, 1'b0, 32'hBFC00020, 4'b1111, 32'd0, 32'h00000000, 0, 32'h00000000, 1'b0, 3);
    fetch_req(32'hBFC00020);
    run(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
